// File: rtl/writeback_queue.sv
// writeback_queue: 4-entry in-order write-back queue arbitrating ALU and load results into the register file.
module writeback_queue #(
   parameter int REG_SELECT_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        AluValid,
   input  logic [DATA_WIDTH-1:0]       AluData,
   input  logic [REG_SELECT_WIDTH-1:0] AluSelect,
   output logic                        AluReady,
   input  logic                        MemValid,
   input  logic [DATA_WIDTH-1:0]       MemData,
   input  logic [REG_SELECT_WIDTH-1:0] MemSelect,
   output logic                        MemReady,
   input  logic                        Hold,
   output logic [DATA_WIDTH-1:0]       WriteData,
   output logic [REG_SELECT_WIDTH-1:0] WriteSelect,
   output logic                        WriteEnable,
   output logic [2:0]                  Count,
   output logic                        Full,
   output logic                        Empty
);
   logic [DATA_WIDTH-1:0] dataMem [4];
   logic [REG_SELECT_WIDTH-1:0] selMem [4];
   logic [1:0] rdPtr, wrPtr;
   logic [2:0] count;
   logic prio, isFull, isEmpty, push;
   always_comb begin
      isFull = count == 3'd4;
      isEmpty = count == 3'd0;
      // Full blocks both sources even if a pop frees a slot this cycle.
      AluReady = !Reset && !isFull && AluValid && (!MemValid || !prio);
      MemReady = !Reset && !isFull && MemValid && (!AluValid || prio);
      push = AluReady || MemReady;
      WriteEnable = !Reset && !isEmpty && !Hold;
      WriteData = Reset ? '0 : dataMem[rdPtr];
      WriteSelect = Reset ? '0 : selMem[rdPtr];
      Count = Reset ? 3'd0 : count;
      Full = !Reset && isFull;
      Empty = Reset || isEmpty;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         prio <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            dataMem[i] <= '0;
            selMem[i] <= '0;
         end
      end else begin
         if (push) begin
            dataMem[wrPtr] <= AluReady ? AluData : MemData;
            selMem[wrPtr] <= AluReady ? AluSelect : MemSelect;
            wrPtr <= wrPtr + 2'd1;
         end
         if (WriteEnable) rdPtr <= rdPtr + 2'd1;
         count <= count + 3'(push) - 3'(WriteEnable);
         // Hand priority to the loser after every contested, non-full cycle.
         if (AluValid && MemValid && !isFull) prio <= !prio;
      end
   end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter REG_SELECT_WIDTH, default 5, register select width matching the register file.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width matching the register file.
REQ-003 SHALL have a fixed queue depth of 4 entries; DEPTH is not a parameter.
REQ-004 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 AluValid  input  1  ALU source offers a write-back.
REQ-007 AluData  input  DATA_WIDTH  ALU write-back value.
REQ-008 AluSelect  input  REG_SELECT_WIDTH  ALU destination register.
REQ-009 AluReady  output  1  ALU offer accepted this cycle when AluValid is high.
REQ-010 MemValid, MemData, MemSelect, MemReady: same directions, widths and meanings as REQ-006..009, for the load unit.
REQ-011 Hold  input  1  freeze draining; no register file write while high.
REQ-012 WriteData  output  DATA_WIDTH  drives register file WriteData.
REQ-013 WriteSelect  output  REG_SELECT_WIDTH  drives register file WriteSelect.
REQ-014 WriteEnable  output  1  drives register file WriteEnable.
REQ-015 Count  output  3  number of occupied entries, 0..4.
REQ-016 Full  output  1  Count == 4.
REQ-017 Empty  output  1  Count == 0.

Function
REQ-018 Circular buffer of 4 {data, select} entries; 2-bit read and write pointers wrap 3->0.
REQ-019 A transfer SHALL occur on a source only when Valid and Ready are both high at posedge Clk.
REQ-020 At most one enqueue per cycle.
REQ-021 Ready rule: both Readys low when Full. When not Full: one source valid -> only its Ready high. Both valid -> only the priority source's Ready high. Neither valid -> both low.
REQ-022 Full SHALL block Ready even when a pop occurs in the same cycle; no same-cycle bypass.
REQ-023 Priority is a 1-bit round-robin flag (0 = ALU).
REQ-024 The priority flag SHALL toggle only after a contested cycle (both valid, not Full), pointing to the loser.
REQ-025 WriteData/WriteSelect SHALL combinationally present the head entry.
REQ-026 WriteEnable = !Empty && !Hold, combinational.
REQ-027 Pop at posedge when WriteEnable is high; the register file samples the same edge.
REQ-028 Latency: an entry enqueued at edge N into an empty queue is written at edge N+1 when Hold is low.
REQ-029 Simultaneous enqueue and pop SHALL leave Count unchanged and advance both pointers.
REQ-030 Ordering: writes SHALL reach the register file in strict acceptance order, including repeated writes to the same select.
REQ-031 Hold SHALL NOT affect acceptance; the queue fills to Full under Hold.
REQ-032 No select value is special; select 0 is queued and written like any other.

Reset
REQ-033 With Reset high at posedge Clk: pointers=0, Count=0, priority=0 (ALU), all entries cleared to 0.
REQ-034 Outputs during reset SHALL be Empty=1, Full=0, WriteEnable=0, WriteData=0, WriteSelect=0.
REQ-035 Readys SHALL be low while Reset is high.
REQ-036 Reset mid-operation SHALL discard all queued entries without writing them.
REQ-037 Reset SHALL override a same-cycle enqueue or pop.

Verification
REQ-038 Single write: reset, then AluValid=1, AluSelect=5, AluData=0xDEADBEEF for one cycle -> next cycle WriteEnable=1, WriteSelect=5, WriteData=0xDEADBEEF, Count=1; the following cycle Empty=1.
REQ-039 Contention: both valid for 4 cycles, ALU data 0xA0..0xA3, Mem data 0xB0..0xB3, Hold=1 -> accepted order A0,B0,A1,B1; Full=1 after 4 edges, both Readys low; release Hold -> 4 writes in that order.
REQ-040 Full blocking with pop: Count=4, Hold=0, MemValid=1 -> MemReady=0 in that cycle; Count drops to 3; MemReady=1 on the next cycle.
REQ-041 Wrap-around: 10 back-to-back single-source writes with Hold=0 -> Count stays 1, writes emitted in order with 1-cycle latency, and pointers wrap without loss.
REQ-042 Reset mid-operation: Count=3, Hold=1, assert Reset one cycle -> Count=0, WriteEnable=0, and no queued data is written after Hold drops.
REQ-043 Same-select ordering: ALU writes select 7 with 0x1, then Mem writes select 7 with 0x2 -> register file writes 0x1 then 0x2 on consecutive edges.
